// File: rtl/tdc_tx_framer.sv
// Buffers TDC stop events in a small FIFO and, on a host read command, frames them into UART bytes.
// Optional trailing XOR checksum byte is built in when TDC_TX_CHECKSUM_EN is defined.
module tdc_tx_framer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt_valid,
    input  logic [5:0]  evt_ch,
    input  logic [23:0] evt_time,
    input  logic        cmd_read,
    input  logic [4:0]  pkt_addr,
    input  logic        uart_ready,
    output logic [7:0]  data_out,
    output logic        data_rdy,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        overflow,
    output logic        busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

`ifdef TDC_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, ADDR, CNT, DATA, WAIT_LO, WAIT_HI, CSUM} state_t;
    localparam state_t END_ST = CSUM;
`else
    typedef enum logic [2:0] {IDLE, HDR, ADDR, CNT, DATA, WAIT_LO, WAIT_HI} state_t;
    localparam state_t END_ST = IDLE;
`endif

    logic [29:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic          push, pop, drop, cnt_emit, emit;
    logic [29:0]   head;

    state_t        state_q, state_d, ret_q, ret_d;
    logic [1:0]    idx_q, idx_d;
    logic [4:0]    rem_q, rem_d, addr_q, addr_d;
    logic [7:0]    dout_q, dout_d, byte_sel;
    logic          rdy_q, rdy_d;
`ifdef TDC_TX_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    assign head = mem[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rdy_d    = 1'b0;
        emit     = 1'b0;
        byte_sel = 8'h00;
        pop      = 1'b0;
        cnt_emit = 1'b0;
`ifdef TDC_TX_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_read) begin
                    state_d = HDR;
                    rem_d   = 5'(count_q);
                    addr_d  = pkt_addr;
                    idx_d   = 2'd0;
`ifdef TDC_TX_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            HDR: begin
                emit     = uart_ready;
                byte_sel = HDR_BYTE;
                ret_d    = ADDR;
            end
            ADDR: begin
                emit     = uart_ready;
                byte_sel = {3'b000, addr_q};
                ret_d    = CNT;
            end
            CNT: begin
                emit     = uart_ready;
                cnt_emit = uart_ready;
                byte_sel = {ovf_q, 2'b00, rem_q};
                ret_d    = (rem_q != 5'd0) ? DATA : END_ST;
            end
            DATA: begin
                emit = uart_ready;
                case (idx_q)
                    2'd0:    byte_sel = {2'b00, head[29:24]};
                    2'd1:    byte_sel = head[23:16];
                    2'd2:    byte_sel = head[15:8];
                    default: byte_sel = head[7:0];
                endcase
                ret_d = DATA;
                if (uart_ready) begin
                    idx_d = idx_q + 2'd1;
                    // the head entry leaves the FIFO with its final byte
                    if (idx_q == 2'd3) begin
                        pop   = 1'b1;
                        rem_d = rem_q - 5'd1;
                        ret_d = (rem_q == 5'd1) ? END_ST : DATA;
                    end
                end
            end
`ifdef TDC_TX_CHECKSUM_EN
            CSUM: begin
                emit     = uart_ready;
                byte_sel = csum_q;
                ret_d    = IDLE;
            end
`endif
            WAIT_LO: if (!uart_ready) state_d = WAIT_HI;
            WAIT_HI: if (uart_ready) state_d = ret_q;
            default: state_d = IDLE;
        endcase

        if (emit) begin
            dout_d  = byte_sel;
            rdy_d   = 1'b1;
            state_d = WAIT_LO;
`ifdef TDC_TX_CHECKSUM_EN
            if (state_q != HDR && state_q != CSUM) csum_d = csum_q ^ byte_sel;
`endif
        end
    end

    always_comb begin
        drop     = evt_valid && full_q && !pop;
        push     = evt_valid && !drop;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        full_d  = (count_d == CW'(FIFO_DEPTH));
        empty_d = (count_d == '0);
        // a drop on the clearing edge wins so no loss goes unreported
        ovf_d = ovf_q;
        if (cnt_emit && ovf_q) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            ret_q    <= IDLE;
            idx_q    <= 2'd0;
            rem_q    <= 5'd0;
            addr_q   <= 5'd0;
            dout_q   <= 8'h00;
            rdy_q    <= 1'b0;
`ifdef TDC_TX_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            ret_q    <= ret_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rdy_q    <= rdy_d;
`ifdef TDC_TX_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {evt_ch, evt_time};
    end

    assign data_out   = dout_q;
    assign data_rdy   = rdy_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_tdc_tx_framer.sv
// Scoreboard bench for tdc_tx_framer: a reference event queue predicts each frame's bytes, a UART model consumes them.
module tb_tdc_tx_framer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        evt_valid;
    logic [5:0]  evt_ch;
    logic [23:0] evt_time;
    logic        cmd_read;
    logic [4:0]  pkt_addr;
    logic        uart_ready;
    logic [7:0]  data_out;
    logic        data_rdy, fifo_full, fifo_empty, overflow, busy;

    logic [7:0]  exp_q[$];
    logic [29:0] mdl_q[$];
    logic        mdl_ovf = 1'b0;
    logic        uart_hold = 1'b0;
    int          n_tests = 0, n_fail = 0, n_rdy = 0, ubusy = 0, n0 = 0, r0 = 0;

    always #5 clk = ~clk;

    tdc_tx_framer #(.FIFO_DEPTH(DEPTH), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_time(evt_time),
        .cmd_read(cmd_read), .pkt_addr(pkt_addr), .uart_ready(uart_ready),
        .data_out(data_out), .data_rdy(data_rdy), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .overflow(overflow), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // UART model: after each accepted byte it is busy for a few cycles, or held off by uart_hold.
    initial begin
        uart_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (data_rdy === 1'b1) begin
                n_rdy++;
                chk("rdy_when_ready", uart_ready, 1);
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("frame_byte", data_out, exp_q.pop_front());
                ubusy = 3;
            end else if (ubusy > 0) begin
                ubusy--;
            end
            uart_ready = (ubusy == 0) && !uart_hold;
        end
    end

    task automatic chk_rst_vals();
        chk("rst_data_rdy", data_rdy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
    endtask

    task automatic write_evt(input logic [5:0] ch, input logic [23:0] t);
        evt_valid = 1'b1; evt_ch = ch; evt_time = t;
        @(negedge clk); #1;
        evt_valid = 1'b0;
        if (mdl_q.size() < DEPTH) mdl_q.push_back({ch, t});
        else mdl_ovf = 1'b1;
    endtask

    task automatic start_frame(input logic [4:0] addr);
        int          n;
        logic [7:0]  cs, b;
        logic [29:0] e;
        logic [7:0]  db[4];
        n = mdl_q.size();
        exp_q.push_back(8'hA5);
        b = {3'b000, addr}; exp_q.push_back(b); cs = b;
        b = {mdl_ovf, 2'b00, 5'(n)}; exp_q.push_back(b); cs ^= b;
        mdl_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = mdl_q.pop_front();
            db[0] = {2'b00, e[29:24]}; db[1] = e[23:16]; db[2] = e[15:8]; db[3] = e[7:0];
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(db[j]);
                cs ^= db[j];
            end
        end
`ifdef TDC_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        cmd_read = 1'b1; pkt_addr = addr;
        @(negedge clk); #1;
        cmd_read = 1'b0;
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 3000 && busy; i++) begin @(negedge clk); #1; end
        chk("frame_done", busy, 0);
        chk("frame_len", exp_q.size(), 0);
        chk("post_empty", fifo_empty, mdl_q.size() == 0);
        chk("post_full", fifo_full, mdl_q.size() == DEPTH);
        chk("post_ovf", overflow, mdl_ovf);
        exp_q.delete();
    endtask

    task automatic wait_rdy(input int target);
        for (int i = 0; i < 2000 && n_rdy < target; i++) begin @(negedge clk); #1; end
        chk("rdy_reached", n_rdy >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: still running, expected to have finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; evt_valid = 1'b0; evt_ch = '0; evt_time = '0; cmd_read = 1'b0; pkt_addr = '0;
        repeat (2) @(negedge clk); #1;
        chk_rst_vals();
        rst = 1'b1;
        @(negedge clk); #1;

        // empty FIFO frame
        start_frame(5'h0A);
        finish_frame();

        // single event frame
        write_evt(6'd5, 24'h123456);
        chk("empty_after_wr", fifo_empty, 0);
        start_frame(5'd3);
        finish_frame();

        // overfill: ninth event dropped, CNT carries the overflow bit
        for (int i = 0; i < 9; i++) write_evt(6'(i * 5), 24'($urandom));
        chk("full_set", fifo_full, 1);
        chk("ovf_set", overflow, 1);
        start_frame(5'h11);
        finish_frame();

        // UART held off mid-frame
        write_evt(6'd47, 24'hABCDEF);
        write_evt(6'd1, 24'h000001);
        n0 = n_rdy;
        fork
            begin start_frame(5'h07); finish_frame(); end
            begin
                wait_rdy(n0 + 4);
                uart_hold = 1'b1;
                repeat (2) begin @(negedge clk); #1; end
                r0 = n_rdy;
                repeat (48) begin @(negedge clk); #1; end
                chk("hold_no_rdy", n_rdy, r0);
                chk("hold_ready_low", uart_ready, 0);
                uart_hold = 1'b0;
            end
        join

        // reset while the framer sits in DATA
        write_evt(6'd12, 24'h0F0F0F);
        write_evt(6'd13, 24'h0E0E0E);
        n0 = n_rdy;
        start_frame(5'h02);
        wait_rdy(n0 + 3);
        for (int i = 0; i < 50 && !uart_ready; i++) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk_rst_vals();
        exp_q.delete(); mdl_q.delete(); mdl_ovf = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        start_frame(5'h1F);
        finish_frame();

        // write while full on the same edge as a pop
        for (int i = 0; i < DEPTH; i++) write_evt(6'(40 + i), 24'($urandom));
        chk("full_before", fifo_full, 1);
        n0 = n_rdy;
        fork
            begin start_frame(5'h15); finish_frame(); end
            begin
                wait_rdy(n0 + 6);
                uart_hold = 1'b1;
                repeat (6) begin @(negedge clk); #1; end
                uart_hold = 1'b0;
                @(negedge clk); #1;
                @(negedge clk); #1;
                evt_valid = 1'b1; evt_ch = 6'd33; evt_time = 24'h5A5A5A;
                @(negedge clk); #1;
                evt_valid = 1'b0;
                chk("full_after_popwr", fifo_full, 1);
                chk("ovf_after_popwr", overflow, 0);
                mdl_q.push_back({6'd33, 24'h5A5A5A});
            end
        join
        start_frame(5'h16);
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
